// File: rtl/pool_frame_fifo_pkg.sv
// Shared definitions for the pooling frame FIFO: entry layout, defaults and
// frame-tagger state encoding.
package pool_frame_fifo_pkg;

  localparam int DATA_WIDTH_DEF = 32;

  // Each FIFO entry is {sof, eof, data}; tag bits sit just above the data.
  localparam int EOF_OFS        = 0;
  localparam int SOF_OFS        = 1;
  localparam int ENTRY_TAG_BITS = 2;

  function automatic int entry_width(input int data_width);
    return data_width + ENTRY_TAG_BITS;
  endfunction

  typedef enum logic {
    IDLE     = 1'b0,
    IN_FRAME = 1'b1
  } frame_state_t;

endpackage

// File: rtl/pool_frame_fifo_fifo.sv
// Generic first-word-fall-through synchronous FIFO with exact occupancy level.
// Head entry is read combinationally from registered storage.
module sync_fifo_fwft #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [WIDTH-1:0]   wdata,
  output logic [WIDTH-1:0]   rdata,
  output logic [$clog2(DEPTH):0] level,
  output logic               full,
  output logic               empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   LVL_ONE = 1;
  localparam logic [AW:0]   LVL_MAX = DEPTH;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_MAX);
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // NOTE: storage is deliberately not reset; validity comes from level alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/pool_frame_fifo.sv
// Captures the pooling output stream into a FWFT FIFO and re-emits it as a
// valid/ready stream tagged with sof/eof. Optional drop counter: define
// POOL_FRAME_FIFO_DROP_CNT_EN.
module pool_frame_fifo
  import pool_frame_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = 16,
  parameter int FRAME_X    = 3,
  parameter int FRAME_Y    = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_sof,
  input  logic                    in_valid,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_sof,
  output logic                    out_eof,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  output logic                    sync_err,
  output logic                    frame_done,
  output logic [15:0]             drop_cnt
);

  localparam int EW        = entry_width(DATA_WIDTH);
  localparam int FRAME_PIX = FRAME_X * FRAME_Y;
  localparam int CW        = $clog2(FRAME_PIX + 1);
  localparam logic [CW-1:0] CNT_ONE  = 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_PIX - 1);

  frame_state_t  state, state_nxt;
  logic [CW-1:0] pix_cnt, cnt_nxt;
  logic          take, tag_sof, tag_eof, desync;
  logic          pop, push, full, empty, drop_full, discard;
  logic [EW-1:0] head, entry;

  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = pix_cnt;
    take      = 1'b0;
    tag_sof   = 1'b0;
    tag_eof   = 1'b0;
    desync    = 1'b0;
    if (in_valid) begin
      if (in_sof) begin
        // A sof inside a frame restarts it; the abandoned frame gets no eof.
        take    = 1'b1;
        tag_sof = 1'b1;
        desync  = (state == IN_FRAME);
        if (FRAME_PIX == 1) begin
          tag_eof   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt   = CNT_ONE;
          state_nxt = IN_FRAME;
        end
      end else if (state == IN_FRAME) begin
        take = 1'b1;
        if (pix_cnt == CNT_LAST) begin
          tag_eof   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = pix_cnt + CNT_ONE;
        end
      end else begin
        desync = 1'b1;
      end
    end
  end

  assign pop       = out_valid && out_ready;
  assign push      = take && (!full || pop);
  assign drop_full = take && full && !pop;
  assign discard   = in_valid && !take;
  assign entry     = {tag_sof, tag_eof, in_data};

  sync_fifo_fwft #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (entry),
    .rdata (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  // Head is gated so stale storage never shows while the FIFO is empty.
  assign out_valid = !empty;
  assign out_data  = out_valid ? head[DATA_WIDTH-1:0] : '0;
  assign out_eof   = out_valid && head[DATA_WIDTH + EOF_OFS];
  assign out_sof   = out_valid && head[DATA_WIDTH + SOF_OFS];

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      pix_cnt    <= '0;
      overflow   <= 1'b0;
      sync_err   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      pix_cnt    <= cnt_nxt;
      overflow   <= overflow | drop_full;
      sync_err   <= sync_err | desync;
      frame_done <= pop && out_eof;
    end
  end

`ifdef POOL_FRAME_FIFO_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      drop_cnt <= '0;
    else if ((drop_full || discard) && (drop_cnt != 16'hFFFF))
      drop_cnt <= drop_cnt + 16'd1;
  end
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_pool_frame_fifo.sv
// Directed bench for pool_frame_fifo: a scoreboard queue holds expected
// output words, compared as the DUT pops them.
module tb_pool_frame_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_sof = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_sof, out_eof;
  logic [LW-1:0] level;
  logic          overflow, sync_err, frame_done;
  logic [15:0]   drop_cnt;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [DW+1:0] sb [$];
  logic [15:0]   exp_drops;

  always #5 clk = ~clk;

  pool_frame_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .FRAME_X    (3),
    .FRAME_Y    (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_sof     (in_sof),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_sof    (out_sof),
    .out_eof    (out_eof),
    .level      (level),
    .overflow   (overflow),
    .sync_err   (sync_err),
    .frame_done (frame_done),
    .drop_cnt   (drop_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pop side: inputs only change just after posedge, so the negedge view
  // matches what the next posedge will pop.
  always @(negedge clk) begin
    if (rst && frame_done) done_cnt++;
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_pop", {30'd0, out_sof, out_eof, out_data}, 64'hDEAD);
      end else begin
        check("pop_word", {30'd0, out_sof, out_eof, out_data}, {30'd0, sb.pop_front()});
      end
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic sof, input bit keep,
                      input bit e_sof, input bit e_eof);
    in_valid = 1'b1;
    in_sof   = sof;
    in_data  = d;
    if (keep) sb.push_back({e_sof, e_eof, d});
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (level != '0 && k < 50) begin @(posedge clk); #1; k++; end
    check(tag, 64'(level), 64'd0);
    check({tag, "_sb"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
`ifdef POOL_FRAME_FIFO_DROP_CNT_EN
    exp_drops = 16'd1;
`else
    exp_drops = 16'd0;
`endif
    // Reset state
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_flags", {61'd0, overflow, sync_err, frame_done}, 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle(2);

    // Basic frame, streaming with out_ready high
    out_ready = 1'b1;
    send(32'd1, 1'b1, 1, 1, 0);
    for (int i = 2; i <= 8; i++) send(32'(i), 1'b0, 1, 0, 0);
    send(32'd9, 1'b0, 1, 0, 1);
    idle(3);
    drain("basic_level");
    check("basic_done", 64'(done_cnt), 64'd1);
    check("basic_flags", {62'd0, overflow, sync_err}, 64'd0);

    // Fill to full, then push+pop while full
    out_ready = 1'b0;
    send(32'd11, 1'b1, 1, 1, 0);
    send(32'd12, 1'b0, 1, 0, 0);
    send(32'd13, 1'b0, 1, 0, 0);
    send(32'd14, 1'b0, 1, 0, 0);
    check("full_level", 64'(level), 64'd4);
    out_ready = 1'b1;
    send(32'd15, 1'b0, 1, 0, 0);
    check("pushpop_level", 64'(level), 64'd4);
    check("pushpop_overflow", 64'(overflow), 64'd0);

    // Drop two words while full; frame position must still advance
    out_ready = 1'b0;
    send(32'd16, 1'b0, 0, 0, 0);
    send(32'd17, 1'b0, 0, 0, 0);
    check("drop_level", 64'(level), 64'd4);
    check("drop_overflow", 64'(overflow), 64'd1);
    check("drop_cnt_full", 64'(drop_cnt), 64'(exp_drops * 16'd2));
    out_ready = 1'b1;
    drain("drop_drain");
    send(32'd18, 1'b0, 1, 0, 0);
    send(32'd19, 1'b0, 1, 0, 1);
    idle(3);
    check("align_done", 64'(done_cnt), 64'd2);

    // Desync from IDLE, then a clean frame
    send(32'hAA, 1'b0, 0, 0, 0);
    check("desync_err", 64'(sync_err), 64'd1);
    check("desync_level", 64'(level), 64'd0);
    check("desync_drop_cnt", 64'(drop_cnt), 64'(exp_drops * 16'd3));
    send(32'd21, 1'b1, 1, 1, 0);
    for (int i = 22; i <= 28; i++) send(32'(i), 1'b0, 1, 0, 0);
    send(32'd29, 1'b0, 1, 0, 1);
    idle(3);
    drain("desync_frame_level");
    check("desync_done", 64'(done_cnt), 64'd3);

    // Mid-frame reset with three words held
    out_ready = 1'b0;
    send(32'd51, 1'b1, 0, 0, 0);
    send(32'd52, 1'b0, 0, 0, 0);
    send(32'd53, 1'b0, 0, 0, 0);
    check("pre_rst_level", 64'(level), 64'd3);
    rst = 1'b0;
    #2;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_level", 64'(level), 64'd0);
    check("mid_rst_flags", {62'd0, overflow, sync_err}, 64'd0);
    check("mid_rst_drop_cnt", 64'(drop_cnt), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle(1);

    // Early restart; sof right after reset also proves the FSM is IDLE
    out_ready = 1'b1;
    send(32'd31, 1'b1, 1, 1, 0);
    send(32'd32, 1'b0, 1, 0, 0);
    send(32'd33, 1'b0, 1, 0, 0);
    send(32'd34, 1'b0, 1, 0, 0);
    check("post_rst_idle", 64'(sync_err), 64'd0);
    send(32'd41, 1'b1, 1, 1, 0);
    check("restart_err", 64'(sync_err), 64'd1);
    for (int i = 42; i <= 48; i++) send(32'(i), 1'b0, 1, 0, 0);
    send(32'd49, 1'b0, 1, 0, 1);
    idle(3);
    drain("restart_level");
    check("final_done", 64'(done_cnt), 64'd4);
    check("final_overflow", 64'(overflow), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pool_frame_fifo.md
Name: pool_frame_fifo

Overview:
Downstream stage of the 2-D pooling block. It captures the pooling output stream (sof-tagged, valid-only, no backpressure) into a small FIFO and re-emits it as a valid/ready stream tagged with sof/eof for the next layer. Frame position is tracked with a pixel counter, and dropped or desynchronised words are flagged.

Parameters:
DATA_WIDTH, 32, pixel word width
DEPTH, 16, FIFO entries; power of two, at least 2
FRAME_X, 3, output frame columns (pooling output width)
FRAME_Y, 3, output frame rows (pooling output height)

Ports:
clk  input  1  single clock; all state on rising edge
rst  input  1  asynchronous active-low reset
in_sof  input  1  first pixel of frame; qualified by in_valid
in_valid  input  1  pixel present on in_data
in_data  input  DATA_WIDTH  pixel from pooling stage
out_ready  input  1  downstream accepts word
out_valid  output  1  word available on out_data
out_data  output  DATA_WIDTH  head-of-FIFO pixel
out_sof  output  1  head word is first pixel of a frame
out_eof  output  1  head word is last pixel (pixel FRAME_X*FRAME_Y-1)
level  output  $clog2(DEPTH)+1  current occupancy
overflow  output  1  sticky: a word was dropped because the FIFO was full
sync_err  output  1  sticky: in_valid arrived outside a frame without in_sof
frame_done  output  1  one-cycle pulse when the eof word is popped
drop_cnt  output  16  dropped-word counter (see Optional Feature)

Behaviour:
- Reset (rst=0, async): FIFO empty; pointers, level, pixel counter = 0; FSM = IDLE. out_valid, out_sof, out_eof, overflow, sync_err, frame_done, drop_cnt = 0; out_data = 0.
- Storage: entries are {sof, eof, data}. Head is read combinationally from registered storage (first-word-fall-through). Push-to-out_valid latency is 1 cycle.
- Pop: happens when out_valid && out_ready.
- Push accepted: when in_valid && state allows && (level < DEPTH || pop this cycle).
  - Full with no pop: word dropped, overflow set. The pixel counter still advances, so frame alignment is kept.
- Simultaneous push and pop: level unchanged. This is legal when full and when holding one word. When empty, the pushed word shows next cycle and there is no bypass.
- Pixel counter: 0..FRAME_X*FRAME_Y-1.
  - The eof tag is set when the counter equals FRAME_X*FRAME_Y-1.
  - The counter wraps to 0 after eof, and the FSM returns to IDLE.
- FSM:
  - IDLE:
    - in_valid && in_sof: tag sof, counter=1, go to IN_FRAME. If FRAME_X*FRAME_Y==1, tag sof and eof together and stay in IDLE.
    - in_valid && !in_sof: word discarded, sync_err set, counter unchanged.
  - IN_FRAME:
    - in_valid && !in_sof: normal pixel; counter increments.
    - eof pixel: go to IDLE.
    - in_valid && in_sof (early restart): sync_err set; word taken as new frame pixel 0 (sof tag, counter=1); stay in IN_FRAME. The previous frame gets no eof tag.
- in_sof without in_valid is ignored.
- level is exact occupancy, 0..DEPTH.
- overflow and sync_err clear only on reset.
- frame_done is registered, asserted the cycle after a pop whose head had eof=1.

Optional Feature:
Macro POOL_FRAME_FIFO_DROP_CNT_EN.
- Defined: drop_cnt increments by 1 on every dropped word (full drop or IDLE discard), saturates at 16'hFFFF, and resets to 0.
- Undefined: counter logic is absent and drop_cnt is tied to 0.
- overflow and sync_err behave identically in both builds.

Decomposition:
- Shared package: DATA_WIDTH default, the entry layout (sof/eof bit positions and the entry-width constant), and the FSM state encoding (IDLE=0, IN_FRAME=1).
- One natural sub-module: sync_fifo_fwft (generic storage, pointers, level, full/empty, push/pop).
  - The frame tagger FSM, pixel counter and flags stay in pool_frame_fifo.

Test Plan:
- Basic frame: FRAME_X=FRAME_Y=3, out_ready=1; send sof+9 valid pixels 1..9 back-to-back. Expect 9 outputs 1..9, out_sof on 1, out_eof on 9, one frame_done pulse, level returns to 0, no flags.
- Backpressure/full: DEPTH=4, out_ready=0; push 6 pixels. Expect level=4, pixels 5 and 6 dropped, overflow=1, drop_cnt=2 (macro on). Then out_ready=1: pops 1..4 in order.
- Full with simultaneous push+pop: level=4, out_ready=1, push one word. Expect word accepted, level stays 4, overflow stays 0.
- Desync: from IDLE send in_valid without sof (data 0xAA). Expect discard, sync_err=1, level=0. Then a proper frame is captured normally.
- Early restart: after 4 pixels send a new sof. Expect sync_err=1, new word tagged sof, and eof only after 9 pixels of the new frame.
- Mid-operation reset: assert rst with level=3 and FSM in IN_FRAME. Expect immediate out_valid=0, level=0, flags cleared, and IDLE after release.
